// File: rtl/mask_pkg.sv
// Shared types, mask constants and helpers for the foreground-mask stage.
package mask_pkg;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   localparam logic [23:0] MASK_FG = 24'hFFFFFF;
   localparam logic [23:0] MASK_BG = 24'h000000;

   // Unsigned |a - b| without wrap-around.
   function automatic logic [7:0] abs_diff8(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] d;
      if (a >= b) begin
         d = a - b;
      end else begin
         d = b - a;
      end
      return d;
   endfunction

endpackage

// File: rtl/mask_gen_if.sv
// FIFO-side bus of the mask stage: frame/background read ports and mask write port.
interface mask_gen_if;

   logic        in_rd_en_frame;
   logic        in_empty_frame;
   logic [23:0] in_dout_frame;
   logic        in_rd_en_bg;
   logic        in_empty_bg;
   logic [23:0] in_dout_bg;
   logic        out_wr_en;
   logic        out_full;
   logic [23:0] out_din;

   modport slave (
      output in_rd_en_frame,
      input  in_empty_frame,
      input  in_dout_frame,
      output in_rd_en_bg,
      input  in_empty_bg,
      input  in_dout_bg,
      output out_wr_en,
      input  out_full,
      output out_din
   );

   modport master (
      input  in_rd_en_frame,
      output in_empty_frame,
      output in_dout_frame,
      input  in_rd_en_bg,
      output in_empty_bg,
      output in_dout_bg,
      input  out_wr_en,
      output out_full,
      input  out_din
   );

endinterface

// File: rtl/rgb_to_gray.sv
// Grayscale conversion for one pixel; the parent registers sum_o and feeds it back as sum_i,
// so the adder sits in stage 1 and the divide-by-3 in stage 2.
module rgb_to_gray
   import mask_pkg::*;
(
   input  rgb_t        pix_i,
   output logic [9:0]  sum_o,
   input  logic [9:0]  sum_i,
   output logic [7:0]  gray_o
);

   assign sum_o  = {2'b00, pix_i.r} + {2'b00, pix_i.g} + {2'b00, pix_i.b};
   // Max sum is 765, so the truncated quotient always fits in 8 bits.
   assign gray_o = 8'(sum_i / 10'd3);

endmodule

// File: rtl/mask_gen.sv
// Foreground mask generator: pops frame/background pixels in lockstep, thresholds the
// grayscale difference in a 3-stage stall-able pipeline and counts written pixels per frame.
module mask_gen
   import mask_pkg::*;
#(
   parameter int unsigned THRESHOLD = 50,
   parameter int unsigned WIDTH     = 720,
   parameter int unsigned HEIGHT    = 540
) (
   input  logic       clock,
   input  logic       reset,
   mask_gen_if.slave  bus,
   output logic       frame_done
);

   localparam int unsigned PIXELS = WIDTH * HEIGHT;
   localparam int unsigned CNT_W  = (PIXELS > 1) ? $clog2(PIXELS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PIXELS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [7:0]       THR      = 8'(THRESHOLD);

   logic             stall_s, pop_s, write_s;
   rgb_t             pix_f_s, pix_b_s;
   logic [9:0]       sum_f_s, sum_b_s;
   logic [7:0]       gray_f_s, gray_b_s;

   logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
   logic [9:0]       sum_f_q, sum_f_d, sum_b_q, sum_b_d;
   logic [7:0]       gray_f_q, gray_f_d, gray_b_q, gray_b_d;
   logic [23:0]      mask3_q, mask3_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             frame_done_q, frame_done_d;

   assign stall_s = v3_q & bus.out_full;
   assign pop_s   = ~bus.in_empty_frame & ~bus.in_empty_bg & ~stall_s;
   assign write_s = v3_q & ~bus.out_full;

   assign pix_f_s = rgb_t'(bus.in_dout_frame);
   assign pix_b_s = rgb_t'(bus.in_dout_bg);

   rgb_to_gray u_gray_frame (
      .pix_i  (pix_f_s),
      .sum_o  (sum_f_s),
      .sum_i  (sum_f_q),
      .gray_o (gray_f_s)
   );

   rgb_to_gray u_gray_bg (
      .pix_i  (pix_b_s),
      .sum_o  (sum_b_s),
      .sum_i  (sum_b_q),
      .gray_o (gray_b_s)
   );

   // Pipeline and counter next-state: every stage holds together while stalled.
   always_comb begin
      v1_d         = stall_s ? v1_q     : pop_s;
      sum_f_d      = stall_s ? sum_f_q  : sum_f_s;
      sum_b_d      = stall_s ? sum_b_q  : sum_b_s;
      v2_d         = stall_s ? v2_q     : v1_q;
      gray_f_d     = stall_s ? gray_f_q : gray_f_s;
      gray_b_d     = stall_s ? gray_b_q : gray_b_s;
      v3_d         = stall_s ? v3_q     : v2_q;
      mask3_d      = stall_s ? mask3_q
                   : ((abs_diff8(gray_f_q, gray_b_q) > THR) ? MASK_FG : MASK_BG);
      cnt_d        = cnt_q;
      frame_done_d = 1'b0;
      if (write_s) begin
         if (cnt_q == CNT_LAST) begin
            cnt_d        = {CNT_W{1'b0}};
            frame_done_d = 1'b1;
         end else begin
            cnt_d        = cnt_q + CNT_ONE;
            frame_done_d = 1'b0;
         end
      end else begin
         cnt_d        = cnt_q;
         frame_done_d = 1'b0;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         v1_q         <= 1'b0;
         v2_q         <= 1'b0;
         v3_q         <= 1'b0;
         sum_f_q      <= 10'd0;
         sum_b_q      <= 10'd0;
         gray_f_q     <= 8'd0;
         gray_b_q     <= 8'd0;
         mask3_q      <= MASK_BG;
         cnt_q        <= {CNT_W{1'b0}};
         frame_done_q <= 1'b0;
      end else begin
         v1_q         <= v1_d;
         v2_q         <= v2_d;
         v3_q         <= v3_d;
         sum_f_q      <= sum_f_d;
         sum_b_q      <= sum_b_d;
         gray_f_q     <= gray_f_d;
         gray_b_q     <= gray_b_d;
         mask3_q      <= mask3_d;
         cnt_q        <= cnt_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign bus.in_rd_en_frame = pop_s;
   assign bus.in_rd_en_bg    = pop_s;
   assign bus.out_wr_en      = write_s;
   assign bus.out_din        = v3_q ? mask3_q : MASK_BG;
   assign frame_done         = frame_done_q;

endmodule

// File: tb/tb_mask_gen.sv
// Directed scoreboard bench for mask_gen (WIDTH=4, HEIGHT=2 so frame wrap is reachable).
module tb_mask_gen;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic frame_done;

   mask_gen_if bus();

   mask_gen #(.THRESHOLD(50), .WIDTH(4), .HEIGHT(2)) dut (
      .clock      (clock),
      .reset      (reset),
      .bus        (bus),
      .frame_done (frame_done)
   );

   always #5 clock = ~clock;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc = 0;
   int          last_wr_cyc = -1;
   int          wr_total = 0;
   int          fd_pulses = 0;
   int          mcnt = 0;
   logic        fd_exp = 1'b0;
   logic        last_pop = 1'b0;
   logic        last_pop_bg = 1'b0;
   logic        last_wr = 1'b0;
   logic [23:0] cur_exp = 24'h0;
   logic [23:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] ref_mask(input logic [23:0] f, input logic [23:0] b);
      int gf, gb, d;
      gf = (int'(f[23:16]) + int'(f[15:8]) + int'(f[7:0])) / 3;
      gb = (int'(b[23:16]) + int'(b[15:8]) + int'(b[7:0])) / 3;
      d  = (gf > gb) ? gf - gb : gb - gf;
      return (d > 50) ? 24'hFFFFFF : 24'h000000;
   endfunction

   // Sample at the falling edge, feed the scoreboard, then step past the rising edge.
   task automatic cycle();
      logic [23:0] e;
      @(negedge clock);
      last_pop = 1'b0; last_pop_bg = 1'b0; last_wr = 1'b0;
      if (!reset) begin
         last_pop    = bus.in_rd_en_frame;
         last_pop_bg = bus.in_rd_en_bg;
         last_wr     = bus.out_wr_en;
         chk("rd_en_lockstep", 32'(bus.in_rd_en_frame), 32'(bus.in_rd_en_bg));
         if (bus.in_empty_frame || bus.in_empty_bg) chk("rd_en_when_empty", 32'(bus.in_rd_en_frame), 32'd0);
         chk("frame_done", 32'(frame_done), 32'(fd_exp));
         if (frame_done === 1'b1) fd_pulses++;
         fd_exp = 1'b0;
         if (bus.in_rd_en_frame === 1'b1) exp_q.push_back(cur_exp);
         if (bus.out_wr_en === 1'b1) begin
            chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("out_din", 32'(bus.out_din), 32'(e));
            end
            fd_exp = (mcnt == 7);
            mcnt   = (mcnt == 7) ? 0 : mcnt + 1;
            wr_total++;
            last_wr_cyc = cyc;
         end
      end
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic set_idle();
      bus.in_empty_frame = 1'b1;
      bus.in_empty_bg    = 1'b1;
      bus.in_dout_frame  = 24'h0;
      bus.in_dout_bg     = 24'h0;
      bus.out_full       = 1'b0;
   endtask

   task automatic set_px(input logic [23:0] f, input logic [23:0] b, input logic [23:0] e);
      bus.in_empty_frame = 1'b0;
      bus.in_empty_bg    = 1'b0;
      bus.in_dout_frame  = f;
      bus.in_dout_bg     = b;
      cur_exp            = e;
   endtask

   task automatic push_px(input string tag, input logic [23:0] f, input logic [23:0] b, input logic [23:0] e);
      set_px(f, b, e);
      cycle();
      chk(tag, 32'(last_pop), 32'd1);
   endtask

   task automatic drain();
      set_idle();
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle();
      chk("drain_empty", 32'(exp_q.size()), 32'd0);
      repeat (2) cycle();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      set_idle();
      exp_q.delete();
      mcnt = 0;
      fd_exp = 1'b0;
      repeat (2) cycle();
      reset = 1'b0;
   endtask

   initial begin
      int c0, w0, p0, idx;
      logic [23:0] f, b;
      logic [23:0] alt_f [6];
      logic [23:0] alt_b [6];
      logic [23:0] alt_e [6];

      set_idle();
      do_reset();
      cycle();
      chk("rst_rd_en", 32'(bus.in_rd_en_frame), 32'd0);
      chk("rst_wr_en", 32'(bus.out_wr_en), 32'd0);
      chk("rst_din", 32'(bus.out_din), 32'h0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      chk("rst_cnt", 32'(dut.cnt_q), 32'd0);

      // Latency: pop in cycle N, write in cycle N+3.
      c0 = cyc;
      push_px("lat_pop", 24'h808080, 24'h808080, 24'h000000);
      set_idle();
      repeat (3) cycle();
      chk("lat_cycle", 32'(last_wr_cyc), 32'(c0 + 3));
      drain();

      push_px("thr_eq_pop", 24'h646464, 24'h323232, 24'h000000);
      push_px("thr_gt_pop", 24'h656565, 24'h323232, 24'hFFFFFF);
      push_px("abs_pop", 24'h000000, 24'h404040, 24'hFFFFFF);
      push_px("trunc_pop", 24'h020000, 24'h000000, 24'h000000);
      drain();

      for (int i = 0; i < 6; i++) begin
         f = 24'($urandom);
         b = 24'($urandom);
         push_px("rand_pop", f, b, ref_mask(f, b));
      end
      drain();

      // Backpressure: out_full high for cycles 2..6 of a 6-pixel alternating stream.
      for (int i = 0; i < 6; i++) begin
         alt_f[i] = (i % 2 == 0) ? 24'h000000 : 24'h808080;
         alt_b[i] = (i % 2 == 0) ? 24'h404040 : 24'h808080;
         alt_e[i] = (i % 2 == 0) ? 24'hFFFFFF : 24'h000000;
      end
      w0 = wr_total;
      idx = 0;
      for (int k = 0; k < 40 && (idx < 6 || exp_q.size() != 0); k++) begin
         if (idx < 6) begin
            set_px(alt_f[idx], alt_b[idx], alt_e[idx]);
         end else begin
            bus.in_empty_frame = 1'b1;
            bus.in_empty_bg    = 1'b1;
         end
         bus.out_full = (k >= 2 && k < 7) ? 1'b1 : 1'b0;
         cycle();
         if (last_pop) idx++;
         if (k >= 3 && k <= 6) begin
            chk("stall_no_pop", 32'(last_pop), 32'd0);
            chk("stall_no_wr", 32'(last_wr), 32'd0);
         end
      end
      chk("bp_all_popped", 32'(idx), 32'd6);
      chk("bp_writes", 32'(wr_total - w0), 32'd6);
      drain();

      // One FIFO empty: no pop on either side, then lockstep resume.
      bus.in_empty_frame = 1'b0;
      bus.in_empty_bg    = 1'b1;
      bus.in_dout_frame  = 24'hC0C0C0;
      bus.in_dout_bg     = 24'h101010;
      cur_exp            = ref_mask(24'hC0C0C0, 24'h101010);
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("bgempty_rd_frame", 32'(last_pop), 32'd0);
         chk("bgempty_rd_bg", 32'(last_pop_bg), 32'd0);
         chk("bgempty_wr", 32'(last_wr), 32'd0);
      end
      bus.in_empty_bg = 1'b0;
      cycle();
      chk("resume_rd_frame", 32'(last_pop), 32'd1);
      chk("resume_rd_bg", 32'(last_pop_bg), 32'd1);
      drain();

      // Frame counting with an 8-pixel frame.
      do_reset();
      p0 = fd_pulses;
      for (int i = 0; i < 8; i++) begin
         f = 24'($urandom);
         b = 24'($urandom);
         push_px("frame_pop", f, b, ref_mask(f, b));
      end
      drain();
      chk("frame_pulses", 32'(fd_pulses - p0), 32'd1);
      chk("frame_cnt_wrap", 32'(dut.cnt_q), 32'd0);
      push_px("ninth_pop", 24'hFFFFFF, 24'h000000, 24'hFFFFFF);
      drain();
      chk("ninth_cnt", 32'(dut.cnt_q), 32'd1);
      chk("ninth_no_pulse", 32'(fd_pulses - p0), 32'd1);

      // Reset with three pixels in flight.
      push_px("inflight_pop0", 24'h000000, 24'hFFFFFF, 24'hFFFFFF);
      push_px("inflight_pop1", 24'h111111, 24'h111111, 24'h000000);
      push_px("inflight_pop2", 24'hFFFFFF, 24'h000000, 24'hFFFFFF);
      reset = 1'b1;
      set_idle();
      exp_q.delete();
      mcnt = 0;
      fd_exp = 1'b0;
      cycle();
      reset = 1'b0;
      w0 = wr_total;
      repeat (4) cycle();
      chk("post_rst_no_wr", 32'(wr_total - w0), 32'd0);
      chk("post_rst_cnt", 32'(dut.cnt_q), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
